// File: rtl/anti_rebond_boutons_pkg.sv
// ----------------------------------------------------------------------------
// anti_rebond_boutons_pkg
// Shared constants for the DeJdr push-button front end (dejdr_const):
// default debounce / auto-repeat timings, counter width and the encodings of
// the suivant auto-repeat FSM.
// ----------------------------------------------------------------------------
package anti_rebond_boutons_pkg;

    // 10 ms debounce, 500 ms first repeat, 200 ms repeat period at 50 MHz.
    localparam int unsigned DEB_CYCLES_DEF = 500000;
    localparam int unsigned REP_DELAY_DEF  = 25000000;
    localparam int unsigned REP_PERIOD_DEF = 10000000;

    // 25 bits hold 25_000_000, the largest default count, without wrap.
    localparam int unsigned CNT_W = 25;

    typedef enum logic [1:0] {
        StRepos      = 2'b00,  // button released
        StAttente    = 2'b01,  // held, waiting REP_DELAY before first repeat
        StRepetition = 2'b10   // held, repeating every REP_PERIOD
    } etat_rep_e;

    // Terminal value of a counter that must fire on its n-th step.
    function automatic logic [CNT_W-1:0] seuil(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/anti_rebond_canal.sv
// ----------------------------------------------------------------------------
// anti_rebond_canal
// One push-button channel: 2-flop synchronizer, mismatch-counting debouncer,
// debounced level and one-cycle press pulse.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   bouton_n_i   raw asynchronous button, 0 when pressed
//   niveau_o     debounced level, 1 while held
//   impulsion_o  one-cycle pulse in the first cycle niveau_o reads 1
//   relache_o    combinational: debounced level falls on the coming edge
// ----------------------------------------------------------------------------
module anti_rebond_canal
    import anti_rebond_boutons_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bouton_n_i,
    output logic niveau_o,
    output logic impulsion_o,
    output logic relache_o
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             niveau_q, niveau_d;
    logic             impulsion_q, impulsion_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             appui_sync;
    logic             bascule;

    always_comb begin
        sync1_d    = bouton_n_i;
        sync2_d    = sync1_q;
        appui_sync = ~sync2_q;
        cnt_d      = '0;
        niveau_d   = niveau_q;
        bascule    = 1'b0;
        // Count consecutive disagreements; any agreement restarts the count.
        if (appui_sync != niveau_q) begin
            if (cnt_q == seuil(DEB_CYCLES)) begin
                bascule  = 1'b1;
                niveau_d = ~niveau_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        impulsion_d = bascule & ~niveau_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            niveau_q    <= 1'b0;
            impulsion_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            niveau_q    <= niveau_d;
            impulsion_q <= impulsion_d;
            cnt_q       <= cnt_d;
        end
    end

    assign niveau_o    = niveau_q;
    assign impulsion_o = impulsion_q;
    assign relache_o   = bascule & niveau_q;

endmodule

// File: rtl/anti_rebond_boutons.sv
// ----------------------------------------------------------------------------
// anti_rebond_boutons
// Debounces the two DeJdr push buttons and adds auto-repeat on "suivant".
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   suivant_n      raw "next die type" button, 0 when pressed
//   lancer_n       raw "roll" button, 0 when pressed
//   suivant        one-cycle pulse per press, plus auto-repeat while held
//   lancer         one-cycle pulse per press, no repeat
//   suivant_appui  debounced level of suivant_n (1 = held)
//   lancer_appui   debounced level of lancer_n (1 = held)
// ----------------------------------------------------------------------------
module anti_rebond_boutons
    import anti_rebond_boutons_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic suivant_n,
    input  logic lancer_n,
    output logic suivant,
    output logic lancer,
    output logic suivant_appui,
    output logic lancer_appui
);

    logic suiv_niveau, suiv_impulsion, suiv_relache;
    logic lanc_niveau, lanc_impulsion;
    // lancer has no auto-repeat, so its release event has no consumer.
    logic lancer_relache_unused;

    etat_rep_e        etat_q, etat_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_q, rep_d;

    anti_rebond_canal #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_canal_suivant (
        .clk_i       (clk),
        .rst_i       (rst),
        .bouton_n_i  (suivant_n),
        .niveau_o    (suiv_niveau),
        .impulsion_o (suiv_impulsion),
        .relache_o   (suiv_relache)
    );

    anti_rebond_canal #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_canal_lancer (
        .clk_i       (clk),
        .rst_i       (rst),
        .bouton_n_i  (lancer_n),
        .niveau_o    (lanc_niveau),
        .impulsion_o (lanc_impulsion),
        .relache_o   (lancer_relache_unused)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            etat_q    <= StRepos;
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            etat_q    <= etat_d;
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
        end
    end

    // Next state. rep_cnt_q holds the cycles elapsed since the last pulse
    // (press or repeat) as seen during the current cycle.
    always_comb begin
        etat_d    = etat_q;
        rep_cnt_d = rep_cnt_q;
        rep_d     = 1'b0;
        unique case (etat_q)
            StRepos: begin
                rep_cnt_d = '0;
                if (suiv_impulsion && !suiv_relache) begin
                    etat_d    = StAttente;
                    // The press-pulse cycle itself is the first elapsed cycle.
                    rep_cnt_d = CNT_W'(1);
                end
            end
            StAttente: begin
                if (suiv_relache) begin
                    etat_d    = StRepos;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == seuil(REP_DELAY)) begin
                    etat_d    = StRepetition;
                    rep_cnt_d = '0;
                    rep_d     = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_W'(1);
                end
            end
            StRepetition: begin
                if (suiv_relache) begin
                    etat_d    = StRepos;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == seuil(REP_PERIOD)) begin
                    rep_cnt_d = '0;
                    rep_d     = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                etat_d    = StRepos;
                rep_cnt_d = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        suivant       = suiv_impulsion | rep_q;
        lancer        = lanc_impulsion;
        suivant_appui = suiv_niveau;
        lancer_appui  = lanc_niveau;
    end

endmodule

// File: tb/tb_anti_rebond_boutons.sv
// ----------------------------------------------------------------------------
// tb_anti_rebond_boutons
// Directed scenarios with literal expectations, then randomized button
// activity, all compared every cycle against a behavioural model: a button
// level flips once the last DEB_CYCLES synchronized samples all disagree with
// it, and suivant repeats at press+REP_DELAY+k*REP_PERIOD while still held.
// ----------------------------------------------------------------------------
module tb_anti_rebond_boutons;

    localparam int DEB = 4;
    localparam int RDL = 10;
    localparam int RPR = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic suivant_n = 1'b1;
    logic lancer_n = 1'b1;
    logic suivant, lancer, suivant_appui, lancer_appui;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    anti_rebond_boutons #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RDL),
        .REP_PERIOD (RPR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .suivant_n     (suivant_n),
        .lancer_n      (lancer_n),
        .suivant       (suivant),
        .lancer        (lancer),
        .suivant_appui (suivant_appui),
        .lancer_appui  (lancer_appui)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (channel 0 = suivant, 1 = lancer) ----
    int edge_no = 0;
    bit raw_h [2][2];     // last raw samples, [0] = most recent
    int n_raw [2];
    bit pr_h  [2][DEB];   // last synchronized "pressed" samples, [0] = most recent
    int n_pr  [2];
    bit m_lvl [2];
    bit m_pulse [2];
    int press_e = -1;
    bit m_suiv = 1'b0;
    bit raw_now [2];
    bit seen;
    bit all_diff;

    initial forever begin
        @(posedge clk);
        edge_no++;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                n_raw[c] = 0;
                n_pr[c] = 0;
                m_lvl[c] = 1'b0;
                m_pulse[c] = 1'b0;
            end
            press_e = -1;
            m_suiv = 1'b0;
        end else begin
            raw_now[0] = suivant_n;
            raw_now[1] = lancer_n;
            for (int c = 0; c < 2; c++) begin
                // A raw sample reaches the debouncer two edges later.
                seen = (n_raw[c] >= 2) ? raw_h[c][1] : 1'b1;
                raw_h[c][1] = raw_h[c][0];
                raw_h[c][0] = raw_now[c];
                n_raw[c]++;
                for (int j = DEB - 1; j > 0; j--) pr_h[c][j] = pr_h[c][j-1];
                pr_h[c][0] = !seen;
                n_pr[c]++;
                m_pulse[c] = 1'b0;
                if (n_pr[c] >= DEB) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++)
                        if (pr_h[c][j] == m_lvl[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_lvl[c] = !m_lvl[c];
                        m_pulse[c] = m_lvl[c];
                        if (c == 0) press_e = m_lvl[c] ? edge_no : -1;
                    end
                end
            end
            m_suiv = m_pulse[0] ||
                     (m_lvl[0] && press_e >= 0 && (edge_no - press_e) >= RDL &&
                      ((edge_no - press_e - RDL) % RPR) == 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_suivant", suivant, m_suiv);
            check("model_lancer", lancer, m_pulse[1]);
            check("model_suivant_appui", suivant_appui, m_lvl[0]);
            check("model_lancer_appui", lancer_appui, m_lvl[1]);
        end
    end

    // ---------------- stimulus ----------------
    bit saw_glitch = 1'b0;
    int run_s = 0;
    int run_l = 0;

    initial begin
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_suivant", suivant, 1'b0);
        check("rst_lancer", lancer, 1'b0);
        check("rst_suivant_appui", suivant_appui, 1'b0);
        check("rst_lancer_appui", lancer_appui, 1'b0);
        rst = 1'b0;
        repeat (3) tick();

        // lancer press: level after edge 5, single pulse, release 5 edges.
        lancer_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 4) check("lancer_appui_e4", lancer_appui, 1'b0);
            if (i == 5) begin
                check("lancer_appui_e5", lancer_appui, 1'b1);
                check("lancer_pulse_e5", lancer, 1'b1);
            end
            if (i == 6) check("lancer_pulse_e6", lancer, 1'b0);
        end
        lancer_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) check("lancer_rel_e4", lancer_appui, 1'b1);
            if (i == 5) begin
                check("lancer_rel_e5", lancer_appui, 1'b0);
                check("lancer_rel_nopulse", lancer, 1'b0);
            end
        end

        // suivant held: pulses at P, P+10, P+15, ...; released so the level
        // falls exactly when the repeat at P+25 is due.
        suivant_n = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (i == 5)  check("suiv_press", suivant, 1'b1);
            if (i == 6)  check("suiv_after_press", suivant, 1'b0);
            if (i == 14) check("suiv_before_rep", suivant, 1'b0);
            if (i == 15) check("suiv_rep1", suivant, 1'b1);
            if (i == 20) check("suiv_rep2", suivant, 1'b1);
            if (i == 24) suivant_n = 1'b1;
            if (i == 25) check("suiv_rep3", suivant, 1'b1);
            if (i == 29) check("suiv_still_held", suivant_appui, 1'b1);
            if (i == 30) begin
                check("suiv_rep_suppressed", suivant, 1'b0);
                check("suiv_released", suivant_appui, 1'b0);
            end
        end
        repeat (5) tick();

        // Both buttons on the same edge.
        suivant_n = 1'b0;
        lancer_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 5) begin
                check("both_suivant", suivant, 1'b1);
                check("both_lancer", lancer, 1'b1);
            end
        end
        suivant_n = 1'b1;
        lancer_n = 1'b1;
        repeat (10) tick();

        // Reset mid-hold in REPETITION, then a fresh press 6 edges later.
        suivant_n = 1'b0;
        repeat (22) tick();
        rst = 1'b1;
        tick();
        check("midrst_suivant", suivant, 1'b0);
        check("midrst_appui", suivant_appui, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 5) check("midrst_appui_e5", suivant_appui, 1'b0);
            if (i == 6) begin
                check("midrst_appui_e6", suivant_appui, 1'b1);
                check("midrst_press", suivant, 1'b1);
            end
        end
        suivant_n = 1'b1;
        repeat (10) tick();

        // Bounce of 1-3 cycle glitches for about 30 cycles.
        for (int c = 0; c < 30; ) begin
            int g;
            g = $urandom_range(1, 3);
            lancer_n = 1'b0;
            for (int k = 0; k < g; k++) begin
                tick();
                if (lancer || lancer_appui) saw_glitch = 1'b1;
            end
            c += g;
            g = $urandom_range(1, 3);
            lancer_n = 1'b1;
            for (int k = 0; k < g; k++) begin
                tick();
                if (lancer || lancer_appui) saw_glitch = 1'b1;
            end
            c += g;
        end
        repeat (10) begin
            tick();
            if (lancer || lancer_appui) saw_glitch = 1'b1;
        end
        check("glitch_quiet", saw_glitch, 1'b0);

        // Randomized runs, with occasional reset.
        for (int c = 0; c < 4000; c++) begin
            if (run_s <= 0) begin
                suivant_n = ~suivant_n;
                run_s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                    : int'($urandom_range(5, 60));
            end
            if (run_l <= 0) begin
                lancer_n = ~lancer_n;
                run_l = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                    : int'($urandom_range(5, 30));
            end
            rst = ($urandom_range(0, 399) == 0);
            run_s--;
            run_l--;
            tick();
        end
        rst = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/anti_rebond_boutons.md
ANTI_REBOND_BOUTONS -- requirements
Module: anti_rebond_boutons

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, consecutive cycles an input must differ from the debounced level before that level changes (10 ms at 50 MHz).
REQ-002 Parameter REP_DELAY, default 25000000, cycles from press pulse to first auto-repeat pulse on suivant (500 ms).
REQ-003 Parameter REP_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses on suivant (200 ms).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 suivant_n  input  1  raw "next die type" push button, asynchronous, 0 when pressed.
REQ-007 lancer_n  input  1  raw "roll" push button, asynchronous, 0 when pressed.
REQ-008 suivant  output  1  one-cycle pulse per debounced press of suivant_n, plus auto-repeat pulses.
REQ-009 lancer  output  1  one-cycle pulse per debounced press of lancer_n, no repeat.
REQ-010 suivant_appui  output  1  debounced level, 1 while suivant_n held.
REQ-011 lancer_appui  output  1  debounced level, 1 while lancer_n held.

Function
REQ-012 Each input SHALL pass through a 2-flop synchronizer before any other logic; channels fully independent.
REQ-013 Per channel, a mismatch counter SHALL increment on each edge where the synchronized input (inverted) differs from the debounced level, and clear to 0 on any edge where they agree.
REQ-014 The debounced level SHALL toggle, and the counter clear, on the edge of the DEB_CYCLES-th consecutive mismatch.
REQ-015 Latency: input sampled low first at edge 0 -> debounced level 1 after edge DEB_CYCLES+1; same for release.
REQ-016 Press pulse SHALL be high exactly during the first cycle the debounced level reads 1; no pulse on release.
REQ-017 Input glitch or bounce shorter than DEB_CYCLES consecutive cycles SHALL produce no level change and no pulse.
REQ-018 Suivant repeat FSM states: REPOS (released), ATTENTE (held, counting REP_DELAY), REPETITION (held, counting REP_PERIOD).
REQ-019 REPOS -> ATTENTE on press pulse, repeat counter cleared.
REQ-020 ATTENTE -> REPETITION with a suivant pulse exactly REP_DELAY cycles after the press pulse.
REQ-021 In REPETITION a suivant pulse SHALL occur every REP_PERIOD cycles while held.
REQ-022 Debounced release in any state SHALL return FSM to REPOS the same edge; a repeat pulse due on that edge is suppressed.
REQ-023 Pulses on suivant SHALL never be wider than one cycle and never on consecutive cycles.
REQ-024 Simultaneous presses on both buttons SHALL yield pulses on both outputs in the same cycle.
REQ-025 Counters SHALL be wide enough for max(DEB_CYCLES, REP_DELAY, REP_PERIOD) without wrap; saturate never reached in legal use.

Reset
REQ-026 On rst: synchronizer flops = 1 (released), debounced levels = 0, counters = 0, FSM = REPOS, suivant = lancer = 0.
REQ-027 Reset mid-press: all state cleared; if button still held after rst deasserts, a new press pulse SHALL follow after REQ-015 latency.
REQ-028 rst SHALL take priority over every other event on the same edge.

Structure
REQ-029 Shared include file dejdr_const.vh SHALL hold default DEB_CYCLES, REP_DELAY, REP_PERIOD, counter width (25 bits), FSM state encodings.
REQ-030 One sub-module anti_rebond_canal (synchronizer, debounce counter, level, press pulse) SHALL be instantiated twice; repeat FSM lives in the top.
REQ-031 Outputs suivant and lancer SHALL drive the DeJdr top-level buttons' consumers directly, with no further conditioning.

Verification (DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=5)
REQ-032 lancer_n low from edge 0, held 20 cycles -> lancer_appui 1 after edge 5; lancer single 1-cycle pulse; no further pulses; release -> level 0 after 5 edges, no pulse.
REQ-033 lancer_n bounces 1-3 cycle glitches for 30 cycles then stable high -> lancer and lancer_appui stay 0 throughout.
REQ-034 suivant_n held 40 cycles -> pulses at press cycle P, P+10, P+15, P+20, P+25, ...; release -> pulses stop, FSM REPOS.
REQ-035 suivant_n released exactly when repeat pulse due -> no pulse that cycle.
REQ-036 Both buttons pressed same edge -> suivant and lancer pulse same cycle.
REQ-037 rst asserted 1 cycle mid-hold in REPETITION -> outputs 0 next cycle; held button gives fresh press pulse 6 edges after rst deasserts.
